clkdiv_ctrl: RTL and testbench
==============================

Name: clkdiv_ctrl

Overview:
Programmable clock-enable divider with a safe reconfiguration controller. A requester writes a divide ratio and an enable over a valid/ready handshake. The block applies each change only at a period boundary, so tick and div_out never produce a runt period. It sits between the register/config logic and the downstream logic that consumes divided enables, and generalises the fixed /2 /4 /8 divide to any ratio N >= 2.

Parameters:
DIV_W, 8, width of divide ratio and internal counter
DEF_DIV, 2, divide ratio loaded at reset; must be >= 2 and < 2**DIV_W

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
cfg_valid  input  1  config request valid
cfg_ready  output  1  controller can accept config
cfg_div  input  DIV_W  requested divide ratio N
cfg_en  input  1  requested run enable
tick  output  1  one-cycle pulse, once per N cycles
div_out  output  1  divided level output
cur_div  output  DIV_W  divide ratio currently in effect
running  output  1  high in RUN or DRAIN
cfg_err  output  1  one-cycle pulse when a request is rejected

Behaviour:
- Clocking and reset: reset is reset, asynchronous, active-high; clock is clock. All state is in flops on posedge clock.
- Reset values: state=IDLE, count=0, cur_div=DEF_DIV, pending=0, tick=0, div_out=0, running=0, cfg_err=0, cfg_ready=1.
- States:
  - IDLE: count held at 0; tick and div_out low.
  - RUN: count increments; it wraps to 0 on the edge where count==cur_div-1.
  - DRAIN: same counting as RUN, with a pending config held.
- cfg_ready = (state != DRAIN). It is decoded from state only, with no combinational path from cfg_valid.
- Accept: cfg_valid & cfg_ready at a rising edge.
- Reject: an accepted request with cfg_div < 2 is dropped. cfg_err pulses for the next cycle; state, cur_div and count are unchanged.
- Accept in IDLE, valid request: at the same edge, cur_div<=cfg_div and count<=0. State goes to RUN if cfg_en, else stays IDLE.
  - First tick occurs in the N-th cycle after acceptance.
- Accept in RUN, valid request: pending<={cfg_div,cfg_en}; state<=DRAIN. The old period continues unchanged.
- DRAIN exit: on the edge where count==cur_div-1:
  - cur_div<=pending div; count<=0.
  - state<=RUN if pending en, else IDLE.
- Coincident edge: if acceptance coincides with the wrap edge of the current period, that wrap uses the old ratio. The new ratio applies at the end of the following period. The rule is "first wrap strictly after acceptance".
- tick = running && count==cur_div-1, decoded from registers only. Exactly one tick per period, including the last old period before a switch.
- div_out = running && count < (cur_div>>1). Duty cycle:
  - Even N: exactly 50%.
  - Odd N: high floor(N/2) cycles, low ceil(N/2) cycles.
- running = state != IDLE.
- Disable: a request with cfg_en=0 while in RUN completes the current period, then goes to IDLE.
- Reset mid-operation: asynchronous return to all reset values; any pending config is discarded.
- Width: count and cur_div are DIV_W bits. The maximum ratio 2**DIV_W-1 must work with no overflow.
- Requester contract: cfg_valid must be low while reset is high. cfg_div and cfg_en must be held stable while cfg_valid & !cfg_ready.

Decomposition:
- Package clkdiv_pkg:
  - state enum {IDLE, RUN, DRAIN}
  - constant MIN_DIV=2
  - default DIV_W
- Natural sub-module: clkdiv_core, containing the counter, wrap detect, and tick/div_out decode.
  - Inputs: clock, reset, run, load, div.
- clkdiv_ctrl holds the FSM, pending register and handshake.

Test Plan:
- Reset release, cfg N=4 en=1 in IDLE -> running=1 next cycle. tick every 4 cycles, first tick in the 4th cycle after accept. div_out pattern 1100 repeating.
- RUN N=4, cfg N=3 accepted at count=1 -> cfg_ready=0 until wrap. One more full 4-cycle period completes, then 3-cycle periods with div_out 100. No short or long period.
- RUN N=4, cfg accepted exactly at the count=3 edge -> one further 4-cycle period, then the new ratio applies. Exactly one tick per period throughout.
- cfg N=1 (and N=0) -> cfg_err pulses 1 cycle, cur_div unchanged, running unchanged, ticks continue undisturbed.
- RUN N=5, cfg en=0 -> current period completes with its tick, then running=0, tick=0, div_out=0, cfg_ready=1.
- Async reset asserted mid-DRAIN -> all outputs at reset values immediately, cur_div=DEF_DIV, pending discarded. Test with DIV_W=8, N=255: 255-cycle period, no overflow.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the programmable clock-enable divider.
// The ratio register and period counter share one width.
package clkdiv_pkg;

  localparam int DIV_W_DEF = 8;
  localparam int MIN_DIV   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/clkdiv_core.sv
// Period counter with wrap detect and the tick / div_out decode.
// load restarts a period at count 0 with a new ratio.
module clkdiv_core
  import clkdiv_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DEF_DIV = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic [DIV_W-1:0] cur_div,
  output logic             wrap,
  output logic             tick,
  output logic             div_out
);

  logic [DIV_W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count   <= '0;
      cur_div <= DEF_DIV[DIV_W-1:0];
    end else if (load) begin
      count   <= '0;
      cur_div <= div;
    end else if (run) begin
      count <= wrap ? '0 : count + 1'b1;
    end else begin
      count <= '0;
    end
  end

  // cur_div is never below 2, so the subtraction cannot underflow
  assign wrap    = (count == cur_div - 1'b1);
  assign tick    = run & wrap;
  assign div_out = run & (count < (cur_div >> 1));

endmodule

// File: rtl/clkdiv_ctrl.sv
// Reconfiguration controller: handshake, pending config and the FSM
// that only swaps the ratio on a period boundary.
module clkdiv_ctrl
  import clkdiv_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DEF_DIV = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_en,
  output logic             tick,
  output logic             div_out,
  output logic [DIV_W-1:0] cur_div,
  output logic             running,
  output logic             cfg_err
);

  state_t           state;
  logic [DIV_W-1:0] pend_div;
  logic             pend_en;
  logic             accept;
  logic             div_ok;
  logic             wrap;
  logic             load;
  logic [DIV_W-1:0] ld_div;

  assign cfg_ready = (state != DRAIN);
  assign running   = (state != IDLE);
  assign accept    = cfg_valid & cfg_ready;
  assign div_ok    = (cfg_div >= DIV_W'(MIN_DIV));

  // a RUN-state request waits in pend_* until the next wrap
  assign load = ((state == IDLE) & accept & div_ok)
              | ((state == DRAIN) & wrap);
  assign ld_div = (state == DRAIN) ? pend_div : cfg_div;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pend_div <= '0;
      pend_en  <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= accept & ~div_ok;
      unique case (state)
        IDLE: begin
          if (accept && div_ok)
            state <= cfg_en ? RUN : IDLE;
        end
        RUN: begin
          if (accept && div_ok) begin
            pend_div <= cfg_div;
            pend_en  <= cfg_en;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          if (wrap)
            state <= pend_en ? RUN : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  clkdiv_core #(
    .DIV_W   (DIV_W),
    .DEF_DIV (DEF_DIV)
  ) u_core (
    .clock   (clock),
    .reset   (reset),
    .run     (running),
    .load    (load),
    .div     (ld_div),
    .cur_div (cur_div),
    .wrap    (wrap),
    .tick    (tick),
    .div_out (div_out)
  );

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Bench for clkdiv_ctrl: directed scenarios then random requests,
// every cycle compared against a period-level reference model.
module tb_clkdiv_ctrl;

  localparam int W   = 8;
  localparam int DEF = 2;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [W-1:0] cfg_div = '0;
  logic         cfg_en = 1'b0;
  logic         tick;
  logic         div_out;
  logic [W-1:0] cur_div;
  logic         running;
  logic         cfg_err;

  int n_checks = 0;
  int n_errors = 0;

  // model: phase within the current period and the ratio in effect
  int m_run, m_phase, m_ratio, m_pend, m_pdiv, m_pen, m_err, m_acc;

  clkdiv_ctrl #(.DIV_W(W), .DEF_DIV(DEF)) dut (
    .clock     (clock),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_en    (cfg_en),
    .tick      (tick),
    .div_out   (div_out),
    .cur_div   (cur_div),
    .running   (running),
    .cfg_err   (cfg_err)
  );

  always #5 clock = ~clock;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_phase = 0; m_ratio = DEF;
    m_pend = 0; m_pdiv = 0; m_pen = 0; m_err = 0; m_acc = 0;
  endtask

  task automatic model_edge();
    int acc, good, wrap;
    acc   = (cfg_valid && !m_pend) ? 1 : 0;
    good  = (int'(cfg_div) >= 2) ? 1 : 0;
    wrap  = (m_run != 0 && m_phase == m_ratio - 1) ? 1 : 0;
    m_acc = acc;
    m_err = (acc != 0 && good == 0) ? 1 : 0;
    if (m_run == 0) begin
      if (acc != 0 && good != 0) begin
        m_ratio = int'(cfg_div);
        m_phase = 0;
        m_run   = cfg_en ? 1 : 0;
      end
    end else begin
      m_phase = (wrap != 0) ? 0 : m_phase + 1;
      if (m_pend != 0) begin
        if (wrap != 0) begin
          m_ratio = m_pdiv;
          m_run   = m_pen;
          m_pend  = 0;
        end
      end else if (acc != 0 && good != 0) begin
        m_pend = 1;
        m_pdiv = int'(cfg_div);
        m_pen  = cfg_en ? 1 : 0;
      end
    end
  endtask

  task automatic check_all();
    chk("tick", tick, (m_run != 0 && m_phase == m_ratio - 1));
    chk("div_out", div_out, (m_run != 0 && m_phase < m_ratio / 2));
    chk("cur_div", cur_div, m_ratio);
    chk("running", running, m_run != 0);
    chk("cfg_ready", cfg_ready, m_pend == 0);
    chk("cfg_err", cfg_err, m_err != 0);
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_all();
  endtask

  task automatic idle(int n);
    cfg_valid = 1'b0;
    repeat (n) cycle();
  endtask

  // asynchronous assertion between edges, visible before the next edge
  task automatic do_reset();
    cfg_valid = 1'b0;
    #2 reset = 1'b1;
    #1 model_reset();
    check_all();
    @(posedge clock);
    @(negedge clock);
    check_all();
    reset = 1'b0;
  endtask

  task automatic req(int d, bit en);
    bit done = 0;
    cfg_valid = 1'b1;
    cfg_div   = W'(d);
    cfg_en    = en;
    for (int i = 0; i < 600 && !done; i++) begin
      cycle();
      if (m_acc != 0) done = 1;
    end
    cfg_valid = 1'b0;
    if (!done) chk("req_timeout", 0, 1);
  endtask

  task automatic wait_phase(int p);
    bit hit = 0;
    cfg_valid = 1'b0;
    for (int i = 0; i < 600 && !hit; i++) begin
      if (m_run != 0 && m_pend == 0 && m_phase == p) hit = 1;
      else cycle();
    end
    if (!hit) chk("wait_timeout", 0, 1);
  endtask

  initial begin
    model_reset();
    @(negedge clock);
    check_all();
    reset = 1'b0;
    idle(2);

    req(4, 1'b1);
    idle(12);
    wait_phase(1);
    req(3, 1'b1);
    idle(12);
    req(4, 1'b1);
    idle(10);
    wait_phase(3);
    req(6, 1'b1);
    idle(20);

    req(1, 1'b1);
    idle(3);
    req(0, 1'b0);
    idle(6);

    req(5, 1'b1);
    idle(12);
    req(5, 1'b0);
    idle(12);

    req(255, 1'b1);
    idle(600);
    req(4, 1'b1);
    idle(20);
    do_reset();
    idle(4);

    for (int i = 0; i < 4000; i++) begin
      if (!(cfg_valid && m_pend != 0)) begin
        int sel;
        cfg_valid = ($urandom_range(0, 9) == 0);
        sel = $urandom_range(0, 19);
        if (sel < 14)      cfg_div = W'($urandom_range(2, 9));
        else if (sel < 17) cfg_div = W'($urandom_range(0, 1));
        else               cfg_div = W'($urandom_range(10, 255));
        cfg_en = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 799) == 0) do_reset();
      else cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
